// File: rtl/flick_arbiter.sv
// Round-robin arbiter that shares one boundFlasher among NREQ requesters:
// grants, pulses flick, then watches the LED bus for end-of-run or timeout.
module flick_arbiter #(
    parameter int NREQ          = 4,
    parameter int LED_W         = 16,
    parameter int FLICK_LEN     = 3,
    parameter int START_TIMEOUT = 8,
    parameter int QUIET         = 4,
    parameter int RUN_TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [LED_W-1:0] led,
    output logic             flick,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic             err,
    output logic             busy
);

    localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          FW = $clog2(FLICK_LEN + 1);
    localparam int          SW = $clog2(START_TIMEOUT + 1);
    localparam int          QW = $clog2(QUIET + 1);
    localparam int          RW = $clog2(RUN_TIMEOUT + 1);
    localparam int unsigned NR = NREQ;

    typedef enum logic [2:0] {IDLE, FLICK, WAIT_START, RUN, DONE, ERR} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [FW-1:0] fcnt;
    logic [SW-1:0] scnt;
    logic [QW-1:0] qcnt;
    logic [RW-1:0] rcnt;

    logic [PW-1:0] sel;
    logic          found;
    int unsigned   j;
    logic [QW-1:0] qnext;
    logic [RW-1:0] rnext;
    logic          quiet_hit;
    logic          run_hit;

    // First requesting index at or after ptr, wrapping modulo NREQ.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < NR; i++) begin
            j = (32'(ptr) + i) % NR;
            if (!found && req[j[PW-1:0]]) begin
                found = 1'b1;
                sel   = j[PW-1:0];
            end
        end
    end

    always_comb begin
        qnext     = (led == '0) ? qcnt + 1'b1 : '0;
        rnext     = rcnt + 1'b1;
        quiet_hit = (qnext == QW'(QUIET));
        run_hit   = (rnext == RW'(RUN_TIMEOUT));
    end

    // Each state clears its own counter on exit, so every counter is zero on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            gidx  <= '0;
            fcnt  <= '0;
            scnt  <= '0;
            qcnt  <= '0;
            rcnt  <= '0;
            flick <= 1'b0;
            gnt   <= '0;
            done  <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt   <= NREQ'(1) << sel;
                        gidx  <= sel;
                        flick <= 1'b1;
                        busy  <= 1'b1;
                        state <= FLICK;
                    end
                end
                FLICK: begin
                    if (fcnt == FW'(FLICK_LEN - 1)) begin
                        fcnt  <= '0;
                        flick <= 1'b0;
                        state <= WAIT_START;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                WAIT_START: begin
                    if (led != '0) begin
                        scnt  <= '0;
                        state <= RUN;
                    end else if (scnt == SW'(START_TIMEOUT - 1)) begin
                        scnt  <= '0;
                        done  <= gnt;
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                RUN: begin
                    // Quiet detection takes priority over the run timeout.
                    if (quiet_hit) begin
                        qcnt  <= '0;
                        rcnt  <= '0;
                        done  <= gnt;
                        state <= DONE;
                    end else if (run_hit) begin
                        qcnt  <= '0;
                        rcnt  <= '0;
                        done  <= gnt;
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        qcnt <= qnext;
                        rcnt <= rnext;
                    end
                end
                DONE, ERR: begin
                    done  <= '0;
                    err   <= 1'b0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    ptr   <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/flick_arbiter.md
# flick_arbiter

Round-robin controller that shares one boundFlasher instance among `NREQ` requesters. It grants one requester at a time and drives the flasher's `flick` input with a fixed-length pulse. It then monitors `led_output` to detect the end of the run and returns a one-cycle `done` (plus `err` on timeout) to the granted requester. It sits between the board-level trigger sources and the flasher.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `LED_W`, 16: width of the flasher LED bus.
- `FLICK_LEN`, 3: cycles `flick` is held high per grant (≥1).
- `START_TIMEOUT`, 8: max cycles in WAIT_START for `led` to go non-zero.
- `QUIET`, 4: consecutive all-zero `led` samples that end a run. Must exceed the flasher's longest in-run all-off interval, which is 1 cycle.
- `RUN_TIMEOUT`, 1024: max cycles in RUN.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  request per requester; level, held until `done`.
- `led`  in  LED_W  flasher `led_output`.
- `flick`  out  1  to flasher `flick`.
- `gnt`  out  NREQ  one-hot grant, high from FLICK through DONE/ERR.
- `done`  out  NREQ  one-cycle pulse on the granted bit at end of service.
- `err`  out  1  one-cycle pulse coincident with `done` when service ended by timeout.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, FLICK, WAIT_START, RUN, DONE, ERR. All outputs are registered.
- IDLE: if `req` ≠ 0, select the first set bit at or after pointer `ptr`, wrapping modulo NREQ. Load `gnt` with that bit and go to FLICK. Otherwise stay.
- FLICK: `flick`=1 for exactly FLICK_LEN cycles (counter), then go to WAIT_START with `flick`=0.
- WAIT_START: if `led` ≠ 0, go to RUN. If START_TIMEOUT cycles elapse with `led`=0, go to ERR.
- RUN: quiet counter increments on each `led`=0 sample and clears on any non-zero sample. When it reaches QUIET, go to DONE. The run counter increments every RUN cycle; at RUN_TIMEOUT go to ERR. If both conditions hit on the same cycle, DONE wins.
- DONE: `done`=`gnt` for one cycle. Then `gnt`←0, `ptr`←(granted index+1) mod NREQ, and go to IDLE.
- ERR: as DONE, but with `err`=1. `ptr` advances identically.
- Deasserting `req` mid-service is ignored: service completes, and `done` is still pulsed.
- `req` changes outside IDLE are not sampled. Re-arbitration happens only in IDLE, so there is a minimum of one IDLE cycle between services.
- Counters are sized `$clog2(max+1)`, clear on every state entry, and never wrap.
- Reset values: state IDLE, `ptr`=0, `flick`=0, `gnt`=0, `done`=0, `err`=0, `busy`=0, all counters 0.
- Reset mid-operation: on the edge where `rst`=1, everything returns to reset values. `flick` drops on that edge, and no `done`/`err` is issued for the aborted service.
- `rst` and `req` asserted together: reset wins. Arbitration occurs on the first edge with `rst`=0.

## Timing
- Request latency: `req` sampled high at IDLE edge k gives `gnt` and `flick` high from edge k (visible in cycle k+1). `busy` rises on the same edge.
- `flick` high for cycles k+1 … k+FLICK_LEN. WAIT_START begins at cycle k+FLICK_LEN+1.
- RUN→DONE: the edge that samples the QUIET-th consecutive zero enters DONE. `done` is high for that single cycle. `gnt`/`busy` fall on the next edge.
- Start timeout: ERR is entered START_TIMEOUT cycles after WAIT_START entry.
- Run timeout: ERR is entered RUN_TIMEOUT cycles after RUN entry.
- Throughput: back-to-back services are separated by exactly one IDLE cycle.
- `gnt` is always one-hot or zero. `done` ⊆ `gnt` on its cycle. `flick` is only high in FLICK.

## Test plan
- Single request: `req`=0100 at IDLE. Expect `gnt`=0100 and `flick`=1 for 3 cycles. Model `led` non-zero 2 cycles later for 50 cycles, then zero. Expect `done`=0100 on the 4th zero-sample edge, `err`=0, and `busy` low next cycle.
- Round robin: `req`=1111 held throughout with normal runs. Expect grant order 0,1,2,3,0 with one IDLE cycle between services. Then `req`=1001 with `ptr`=1: expect grant 3, then 0.
- In-run gap: `led` drops to 0 for 1 cycle at the L0 turnaround, then 3 zero cycles, then non-zero again. Expect no `done`; the quiet counter clears each time.
- Start timeout: grant issued, `led` stuck at 0. Expect `err`=1 and `done`=grant bit exactly 8 cycles after WAIT_START entry, and `ptr` advanced.
- Run timeout: `led` stuck at 16'h0001. Expect `err` pulse 1024 cycles after RUN entry, then IDLE.
- Reset mid-FLICK: assert `rst` during the 2nd `flick` cycle. Next edge: all outputs 0, `ptr`=0. Held `req` is re-arbitrated on the first edge after `rst` releases.
